// File: rtl/xcore_gnrl_rr_grant.sv
// xcore_gnrl_rr_grant: round-robin grant generator driving the one-hot
// select vector of the signal/scl multiplexing arbiter. A winner is picked
// in IDLE by scanning the requests from the rotating priority pointer. It
// keeps the grant until it signals done, withdraws its request, or its hold
// time runs out. Priority then moves just past that owner, and the grant
// only returns after a one-cycle IDLE bubble.
module xcore_gnrl_rr_grant #(
  parameter  int SIG_NUM  = 4,
  parameter  int MAX_HOLD = 16,
  localparam int IDX_W    = $clog2(SIG_NUM)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [SIG_NUM-1:0] req_i,
  input  logic               done_i,
  output logic [SIG_NUM-1:0] scl_o,
  output logic               gnt_vld_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               tmo_o
);

  // Hold counter runs 0..MAX_HOLD-1. Keep at least one bit so that
  // MAX_HOLD=1 still elaborates cleanly.
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e             state_q,    state_d;
  logic [IDX_W-1:0]   ptr_q,      ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [SIG_NUM-1:0] scl_q,      scl_d;
  logic               gnt_vld_q,  gnt_vld_d;
  logic [IDX_W-1:0]   gnt_idx_q,  gnt_idx_d;
  logic               tmo_q,      tmo_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     scan;
  logic               rel_normal;
  logic               rel_tmo;

  // Rotating priority scan: find the first request at ptr, ptr+1, ... mod SIG_NUM.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int i = 0; i < SIG_NUM; i++) begin
      // One extra bit makes room for the sum before the wrap. SIG_NUM need
      // not be a power of two, so the wrap subtracts SIG_NUM explicitly.
      scan = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (scan >= (IDX_W+1)'(SIG_NUM)) begin
        scan = scan - (IDX_W+1)'(SIG_NUM);
      end
      if (!win_found && req_i[scan[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IDX_W-1:0];
      end
    end
  end

  // Next-state logic: grant from IDLE, hold or release from BUSY.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    scl_d      = scl_q;
    gnt_vld_d  = gnt_vld_q;
    gnt_idx_d  = gnt_idx_q;
    tmo_d      = 1'b0;
    rel_normal = 1'b0;
    rel_tmo    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // done_i is ignored here; only a non-empty request starts a grant.
        if (win_found) begin
          scl_d      = {{(SIG_NUM-1){1'b0}}, 1'b1} << win_idx;
          gnt_vld_d  = 1'b1;
          gnt_idx_d  = win_idx;
          hold_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        rel_normal = done_i || !req_i[gnt_idx_q];
        rel_tmo    = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
        if (rel_normal || rel_tmo) begin
          scl_d     = '0;
          gnt_vld_d = 1'b0;
          ptr_d     = (gnt_idx_q == IDX_W'(SIG_NUM - 1)) ? '0 : gnt_idx_q + 1'b1;
          // A timeout that coincides with a normal release is reported as normal.
          tmo_d     = rel_tmo && !rel_normal;
          state_d   = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      scl_q      <= '0;
      gnt_vld_q  <= 1'b0;
      gnt_idx_q  <= '0;
      tmo_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      scl_q      <= scl_d;
      gnt_vld_q  <= gnt_vld_d;
      gnt_idx_q  <= gnt_idx_d;
      tmo_q      <= tmo_d;
    end
  end

  assign scl_o     = scl_q;
  assign gnt_vld_o = gnt_vld_q;
  assign gnt_idx_o = gnt_idx_q;
  assign tmo_o     = tmo_q;

endmodule

// File: tb/tb_xcore_gnrl_rr_grant.sv
// Testbench for xcore_gnrl_rr_grant. Directed scenarios come first, then
// randomized traffic. Both are checked against a behavioural model that
// tracks the current owner, how many cycles it has held the grant, and
// where the next scan starts.
module tb_xcore_gnrl_rr_grant;

  localparam int N    = 4;
  localparam int HOLD = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;
  logic [N-1:0] scl;
  logic         gnt_vld;
  logic [1:0]   gnt_idx;
  logic         tmo;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int m_owner = -1;  // -1 means nobody holds the grant
  int m_age   = 0;   // cycles the current owner has seen scl set
  int m_next  = 0;   // first index scanned at the next arbitration
  int m_idx   = 0;   // last granted index
  bit m_tmo   = 1'b0;

  xcore_gnrl_rr_grant #(.SIG_NUM(N), .MAX_HOLD(HOLD)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .done_i    (done),
    .scl_o     (scl),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx),
    .tmo_o     (tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step(input logic [N-1:0] r, input bit d, input bit rs);
    bit by_done, by_withdraw, by_time;
    if (rs) begin
      m_owner = -1; m_age = 0; m_next = 0; m_idx = 0; m_tmo = 1'b0;
    end else if (m_owner < 0) begin
      m_tmo = 1'b0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_next + k) % N;
        if (r[j]) begin
          m_owner = j; m_idx = j; m_age = 1;
          break;
        end
      end
    end else begin
      by_done     = d;
      by_withdraw = !r[m_owner];
      by_time     = (m_age == HOLD);
      if (by_done || by_withdraw || by_time) begin
        m_tmo   = by_time && !by_done && !by_withdraw;
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_age++;
        m_tmo = 1'b0;
      end
    end
  endtask

  // Drive inputs (called just after a falling edge), clock once, then
  // compare every output with the model half a cycle later.
  task automatic apply(input logic [N-1:0] r, input bit d, input bit rs);
    logic [N-1:0] exp_scl;
    req = r; done = d; rst = rs;
    @(posedge clk);
    model_step(r, d, rs);
    @(negedge clk);
    exp_scl = (m_owner < 0) ? '0 : N'(1) << m_owner;
    check("scl",     32'(scl),     32'(exp_scl));
    check("gnt_vld", 32'(gnt_vld), 32'(m_owner >= 0));
    check("gnt_idx", 32'(gnt_idx), 32'(m_idx));
    check("tmo",     32'(tmo),     32'(m_tmo));
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] rot_seq [9];
    bit d, rs;

    rot_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};

    @(negedge clk);

    // Reset, then a single request.
    apply('0, 1'b0, 1'b1);
    apply('0, 1'b0, 1'b1);
    check("rst_scl", 32'(scl),     32'h0);
    check("rst_vld", 32'(gnt_vld), 32'h0);
    apply(4'b0100, 1'b0, 1'b0);
    check("single_scl", 32'(scl),     32'b0100);
    check("single_idx", 32'(gnt_idx), 32'd2);
    check("single_vld", 32'(gnt_vld), 32'd1);
    apply(4'b0100, 1'b1, 1'b0);
    check("single_rel", 32'(scl), 32'h0);
    // The pointer is now at 3, so the first pick from all-ones is index 3.
    apply(4'b1111, 1'b0, 1'b0);
    check("ptr3_scl", 32'(scl), 32'b1000);

    // Round-robin rotation with done held high from reset.
    apply(4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      apply(4'b1111, 1'b1, 1'b0);
      check($sformatf("rot_%0d", i), 32'(scl), 32'(rot_seq[i]));
    end

    // Timeout: 16 cycles of grant, a one-cycle tmo bubble, then a regrant.
    apply('0, 1'b0, 1'b1);
    for (int i = 0; i < HOLD; i++) begin
      apply(4'b0010, 1'b0, 1'b0);
      check($sformatf("hold_%0d", i), 32'(scl), 32'b0010);
      check($sformatf("hold_tmo_%0d", i), 32'(tmo), 32'd0);
    end
    apply(4'b0010, 1'b0, 1'b0);
    check("tmo_scl",  32'(scl), 32'h0);
    check("tmo_flag", 32'(tmo), 32'd1);
    apply(4'b0010, 1'b0, 1'b0);
    check("regrant_scl", 32'(scl), 32'b0010);
    check("regrant_tmo", 32'(tmo), 32'd0);

    // Owner withdrawal with wrap-around: move ptr to 3, grant 3, then drop req[3].
    apply('0, 1'b0, 1'b1);
    apply(4'b0100, 1'b0, 1'b0);
    apply(4'b0100, 1'b1, 1'b0);
    apply(4'b1011, 1'b0, 1'b0);
    check("wd_own3", 32'(scl), 32'b1000);
    apply(4'b0011, 1'b0, 1'b0);
    check("wd_scl", 32'(scl), 32'h0);
    check("wd_tmo", 32'(tmo), 32'd0);
    apply(4'b0011, 1'b0, 1'b0);
    check("wd_wrap", 32'(scl), 32'b0001);

    // Reset in the middle of a grant of index 3.
    apply(4'b0011, 1'b1, 1'b0);
    apply(4'b1000, 1'b0, 1'b0);
    check("mid_busy", 32'(scl), 32'b1000);
    apply(4'b1000, 1'b0, 1'b1);
    check("mid_scl", 32'(scl),     32'h0);
    check("mid_idx", 32'(gnt_idx), 32'd0);
    check("mid_vld", 32'(gnt_vld), 32'd0);
    check("mid_tmo", 32'(tmo),     32'd0);
    apply(4'b1000, 1'b0, 1'b0);
    check("mid_regrant", 32'(scl), 32'b1000);

    // done arriving on the same edge as the timeout counts as a normal release.
    apply('0, 1'b0, 1'b1);
    for (int i = 0; i < HOLD; i++) apply(4'b0010, 1'b0, 1'b0);
    apply(4'b0010, 1'b1, 1'b0);
    check("sim_scl", 32'(scl), 32'h0);
    check("sim_tmo", 32'(tmo), 32'd0);

    // Randomized traffic. req changes only occasionally and done is rare,
    // so long holds and timeouts still occur.
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) r = N'($urandom);
      d  = ($urandom_range(15) == 0);
      rs = ($urandom_range(299) == 0);
      apply(r, d, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
